alu_seq_ex: RTL and testbench

ALU_SEQ_EX -- requirements
Module: alu_seq_ex

---
 rtl/alu_seq_ex_pkg.sv | 40 ++++
 rtl/alu_seq_muldiv.sv | 77 +++++++
 rtl/alu_seq_ex.sv | 151 +++++++++++++++
 tb/tb_alu_seq_ex.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ex_pkg.sv
// Shared opcode map, flag bit positions and datapath types for the sequential ALU.
package alu_seq_ex_pkg;

    localparam logic [5:0] ALO_ADD  = 6'd0;
    localparam logic [5:0] ALO_ADDI = 6'd1;
    localparam logic [5:0] ALO_SUB  = 6'd2;
    localparam logic [5:0] ALO_SUBI = 6'd3;
    localparam logic [5:0] ALO_NOT  = 6'd4;
    localparam logic [5:0] ALO_NOTI = 6'd5;
    localparam logic [5:0] ALO_ORL  = 6'd6;
    localparam logic [5:0] ALO_ORLI = 6'd7;
    localparam logic [5:0] ALO_AND  = 6'd8;
    localparam logic [5:0] ALO_ANDI = 6'd9;
    localparam logic [5:0] ALO_XOR  = 6'd10;
    localparam logic [5:0] ALO_XORI = 6'd11;
    localparam logic [5:0] ALO_SLL  = 6'd12;
    localparam logic [5:0] ALO_SRL  = 6'd13;
    localparam logic [5:0] ALO_SRA  = 6'd14;
    localparam logic [5:0] ALO_SLS  = 6'd15;
    localparam logic [5:0] ALO_SLSI = 6'd16;
    localparam logic [5:0] ALO_SLTU = 6'd17;
    localparam logic [5:0] ALO_LDW  = 6'd18;
    localparam logic [5:0] ALO_SVW  = 6'd19;
    localparam logic [5:0] ALO_MIRL = 6'd20;
    localparam logic [5:0] ALO_MIRH = 6'd21;
    localparam logic [5:0] ALO_MUL  = 6'd22;
    localparam logic [5:0] ALO_DIVU = 6'd23;
    localparam logic [5:0] ALO_REMU = 6'd24;

    localparam int unsigned FLAG_CARRY    = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_ZERO     = 2;
    localparam int unsigned FLAG_DIV_ZERO = 3;
    localparam int unsigned FLAG_ILLEGAL  = 4;

    typedef enum logic [1:0] {MdMul, MdDivu, MdRemu} md_op_e;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module alu_seq_muldiv
    import alu_seq_ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  md_op_e            op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              div_zero_o,
    output logic              mul_ovf_o
);
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    md_op_e              op_q, op_d;
    // {high, low}: product accumulator for MUL, {remainder, quotient} for DIVU/REMU.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opb_q, opb_d;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem;

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        acc_d = acc_q;
        opb_d = opb_q;

        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge    = div_shift >= {1'b0, opb_q};
        div_rem   = div_ge ? DATA_W'(div_shift - {1'b0, opb_q}) : div_shift[DATA_W-1:0];

        if (start_i) begin
            cnt_d = CNT_W'(DATA_W);
            op_d  = op_i;
            acc_d = {{DATA_W{1'b0}}, a_i};
            opb_d = b_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (op_q == MdMul) begin
                acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            end else begin
                acc_d = {div_rem, acc_q[DATA_W-2:0], div_ge};
            end
        end
    end

    // Result is taken from the final iteration's next state so DONE follows CALC directly.
    assign done_o     = (cnt_q == CNT_W'(1)) && !start_i;
    assign result_o   = (op_q == MdRemu) ? acc_d[2*DATA_W-1:DATA_W] : acc_d[DATA_W-1:0];
    assign div_zero_o = (op_q != MdMul) && (opb_q == '0);
    assign mul_ovf_o  = (op_q == MdMul) && (acc_d[2*DATA_W-1:DATA_W] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= MdMul;
            acc_q <= '0;
            opb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
        end
    end

endmodule

// File: rtl/alu_seq_ex.sv
// Sequential execute-stage ALU: single-cycle ops registered straight into DONE,
// MUL/DIVU/REMU routed through the iterative muldiv unit.
module alu_seq_ex
    import alu_seq_ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPC_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  alu_op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd_value,
    output logic [4:0]        flags
);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned MW      = (DATA_W < 16) ? DATA_W : 16;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [4:0]        flags_q, flags_d;

    logic              accept;
    logic [DATA_W:0]   sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] sc_res;
    logic              sc_c, sc_v, sc_ill, is_md;
    md_op_e            md_op;
    logic              md_start, md_done, md_dz, md_ovf;
    logic [DATA_W-1:0] md_res;

    assign accept = in_valid && (state_q == StIdle);
    assign sum    = {1'b0, rs} + {1'b0, rt};
    assign diff   = {1'b0, rs} - {1'b0, rt};
    assign shamt  = rt[SHAMT_W-1:0];

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        is_md  = 1'b0;
        md_op  = MdMul;
        case (alu_op)
            OPC_W'(ALO_ADD), OPC_W'(ALO_ADDI): begin
                sc_res = sum[DATA_W-1:0];
                sc_c   = sum[DATA_W];
                sc_v   = (rs[DATA_W-1] == rt[DATA_W-1]) && (sum[DATA_W-1] != rs[DATA_W-1]);
            end
            OPC_W'(ALO_SUB), OPC_W'(ALO_SUBI): begin
                sc_res = diff[DATA_W-1:0];
                sc_c   = diff[DATA_W];
                sc_v   = (rs[DATA_W-1] != rt[DATA_W-1]) && (diff[DATA_W-1] != rs[DATA_W-1]);
            end
            OPC_W'(ALO_NOT):                   sc_res = ~rs;
            OPC_W'(ALO_NOTI):                  sc_res = ~rt;
            OPC_W'(ALO_ORL), OPC_W'(ALO_ORLI): sc_res = rs | rt;
            OPC_W'(ALO_AND), OPC_W'(ALO_ANDI): sc_res = rs & rt;
            OPC_W'(ALO_XOR), OPC_W'(ALO_XORI): sc_res = rs ^ rt;
            OPC_W'(ALO_SLL):                   sc_res = rs << shamt;
            OPC_W'(ALO_SRL):                   sc_res = rs >> shamt;
            OPC_W'(ALO_SRA):                   sc_res = $unsigned($signed(rs) >>> shamt);
            OPC_W'(ALO_SLS), OPC_W'(ALO_SLSI): sc_res = DATA_W'($signed(rs) < $signed(rt));
            OPC_W'(ALO_SLTU):                  sc_res = DATA_W'(rs < rt);
            OPC_W'(ALO_LDW), OPC_W'(ALO_SVW):  sc_res = sum[DATA_W-1:0];
            OPC_W'(ALO_MIRL):                  sc_res[MW-1:0] = rt[MW-1:0];
            OPC_W'(ALO_MIRH):                  sc_res[DATA_W-1 -: MW] = rt[MW-1:0];
            OPC_W'(ALO_MUL): begin
                is_md = 1'b1;
                md_op = MdMul;
            end
            OPC_W'(ALO_DIVU): begin
                is_md = 1'b1;
                md_op = MdDivu;
            end
            OPC_W'(ALO_REMU): begin
                is_md = 1'b1;
                md_op = MdRemu;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        flags_d  = flags_q;
        md_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && is_md) begin
                    md_start = 1'b1;
                    state_d  = StCalc;
                end else if (accept) begin
                    state_d = StDone;
                    rd_d    = sc_res;
                    flags_d = {sc_ill, 1'b0, sc_res == '0, sc_v, sc_c};
                end
            end
            StCalc: begin
                if (md_done) begin
                    state_d = StDone;
                    rd_d    = md_res;
                    flags_d = {1'b0, md_dz, md_res == '0, md_ovf, 1'b0};
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rd_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            flags_q <= flags_d;
        end
    end

    alu_seq_muldiv #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start_i   (md_start),
        .op_i      (md_op),
        .a_i       (rs),
        .b_i       (rt),
        .done_o    (md_done),
        .result_o  (md_res),
        .div_zero_o(md_dz),
        .mul_ovf_o (md_ovf)
    );

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign rd_value  = rd_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_ex.sv
// Directed table-driven bench for alu_seq_ex plus hand sequences for divide-by-zero hold
// and reset abort during a multiply.
module tb_alu_seq_ex;
    import alu_seq_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_op;
    logic [31:0] rs, rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd_value;
    logic [4:0]  flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_ex #(
        .DATA_W(32),
        .OPC_W (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .rs       (rs),
        .rt       (rt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rd_value (rd_value),
        .flags    (flags)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE, wait (bounded) for out_valid, check, then retire it.
    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [4:0] exp_fl, input int exp_lat);
        int lat;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        alu_op   = op;
        rs       = a;
        rt       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " rd_value"}, 64'(rd_value), 64'(exp_res));
        check({name, " flags"}, 64'(flags), 64'(exp_fl));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int  seen;
        logic [5:0] bad_op;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        rs        = '0;
        rt        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset rd_value", 64'(rd_value), 64'd0);
        check("reset flags", 64'(flags), 64'd0);

        bad_op = 6'h3F;
        // flags = {illegal, div_zero, zero, overflow, carry}
        vecs.push_back('{"add_carry", ALO_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00101, 1});
        vecs.push_back('{"sub_ovf", ALO_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b00010, 1});
        vecs.push_back('{"sra", ALO_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 5'b00000, 1});
        vecs.push_back('{"mul_ovf", ALO_MUL, 32'h1_0000, 32'h1_0000, 32'h0, 5'b00110, 33});
        vecs.push_back('{"divu", ALO_DIVU, 32'd100, 32'd7, 32'd14, 5'b00000, 33});
        vecs.push_back('{"remu", ALO_REMU, 32'd100, 32'd7, 32'd2, 5'b00000, 33});
        vecs.push_back('{"mul", ALO_MUL, 32'd123, 32'd456, 32'd56088, 5'b00000, 33});
        vecs.push_back('{"addi", ALO_ADDI, 32'd7, 32'd8, 32'd15, 5'b00000, 1});
        vecs.push_back('{"sub_borrow", ALO_SUB, 32'd1, 32'd2, 32'hFFFF_FFFF, 5'b00001, 1});
        vecs.push_back('{"add_ovf", ALO_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00010, 1});
        vecs.push_back('{"and", ALO_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b0, 1});
        vecs.push_back('{"orl", ALO_ORL, 32'h0F, 32'hF0, 32'hFF, 5'b00000, 1});
        vecs.push_back('{"xor", ALO_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 5'b0, 1});
        vecs.push_back('{"not", ALO_NOT, 32'h0, 32'h1234, 32'hFFFF_FFFF, 5'b00000, 1});
        vecs.push_back('{"noti", ALO_NOTI, 32'h5, 32'hFFFF_FFFF, 32'h0, 5'b00100, 1});
        vecs.push_back('{"sll", ALO_SLL, 32'h1, 32'h1F, 32'h8000_0000, 5'b00000, 1});
        vecs.push_back('{"srl", ALO_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 5'b00000, 1});
        vecs.push_back('{"sls", ALO_SLS, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000, 1});
        vecs.push_back('{"sltu", ALO_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00100, 1});
        vecs.push_back('{"mirl", ALO_MIRL, 32'h0, 32'h1234_5678, 32'h0000_5678, 5'b00000, 1});
        vecs.push_back('{"mirh", ALO_MIRH, 32'h0, 32'h1234_5678, 32'h5678_0000, 5'b00000, 1});
        vecs.push_back('{"ldw", ALO_LDW, 32'h1000, 32'h24, 32'h1024, 5'b00000, 1});
        vecs.push_back('{"svw_wrap", ALO_SVW, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00100, 1});
        vecs.push_back('{"illegal", bad_op, 32'h55, 32'h66, 32'h0, 5'b10100, 1});

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl,
                   vecs[i].lat);
        end

        // DIVU by zero: result held through 10 stalled cycles, extra request ignored.
        in_valid = 1'b1;
        alu_op   = ALO_DIVU;
        rs       = 32'd5;
        rt       = 32'd0;
        @(posedge clk);
        #1;
        alu_op = ALO_ADD;
        seen   = 1;
        while (!out_valid && seen < 100) begin
            check("div0 busy in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            seen++;
        end
        check("div0 latency", 64'(seen), 64'd33);
        for (int c = 0; c < 10; c++) begin
            check("div0 hold rd_value", 64'(rd_value), 64'hFFFF_FFFF);
            check("div0 hold flags", 64'(flags), 64'(5'b01000));
            check("div0 hold in_ready", 64'(in_ready), 64'd0);
            check("div0 hold out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("div0 retire in_ready", 64'(in_ready), 64'd1);

        // Reset pulse during the fifth cycle of a MUL aborts it silently.
        in_valid = 1'b1;
        alu_op   = ALO_MUL;
        rs       = 32'd9;
        rt       = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort rd_value", 64'(rd_value), 64'd0);
        check("abort flags", 64'(flags), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no result", 64'(seen), 64'd0);
        run_op("add_after_abort", ALO_ADD, 32'd2, 32'd3, 32'd5, 5'b00000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
